// File: rtl/output_drain_controller_pkg.sv
`default_nettype none
// ============================================================================
//  output_drain_controller_pkg
//  Shared state encoding, read-latency constants and lane-index sizing.
//  Revision: 1.0
// ============================================================================
package output_drain_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_STREAM  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int LAT_TRANSCONV = 1;
  localparam int LAT_1DCONV    = 2;
  localparam int WAIT_W        = 2;

  function automatic int lane_idx_width(input int num_brams);
    return (num_brams > 1) ? $clog2(num_brams) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/output_drain_controller_row_serializer.sv
`default_nettype none
// ============================================================================
//  output_drain_controller_row_serializer
//  Holds one captured row and emits it lane by lane on a valid/ready stream.
//  Revision: 1.0
// ============================================================================
module output_drain_controller_row_serializer
  import output_drain_controller_pkg::*;
#(
  parameter int DW        = 16,
  parameter int NUM_BRAMS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_load,
  input  logic                    i_last_row,
  input  logic                    i_enable,
  input  logic [NUM_BRAMS*DW-1:0] i_row_data_flat,
  input  logic                    i_tready,
  output logic [DW-1:0]           o_tdata,
  output logic                    o_tvalid,
  output logic                    o_tlast,
  output logic                    o_row_done
);

  localparam int c_lane_w = lane_idx_width(NUM_BRAMS);
  localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(NUM_BRAMS - 1);

  logic [DW-1:0]       r_rowbuf [NUM_BRAMS];
  logic [c_lane_w-1:0] r_lane;
  logic                r_last_row;
  logic                w_last_lane;
  logic                w_accept;

  assign w_last_lane = (r_lane == c_last_lane);
  assign w_accept    = i_enable && i_tready;

  // Lane only advances on acceptance, so data and last stay frozen across stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BRAMS; i++) r_rowbuf[i] <= '0;
      r_lane     <= '0;
      r_last_row <= 1'b0;
    end else if (i_load) begin
      for (int i = 0; i < NUM_BRAMS; i++) r_rowbuf[i] <= i_row_data_flat[i*DW +: DW];
      r_lane     <= '0;
      r_last_row <= i_last_row;
    end else if (w_accept) begin
      r_lane <= w_last_lane ? '0 : r_lane + c_lane_w'(1);
    end
  end

  assign o_tvalid   = i_enable;
  assign o_tdata    = i_enable ? r_rowbuf[r_lane] : '0;
  assign o_tlast    = i_enable && r_last_row && w_last_lane;
  assign o_row_done = w_accept && w_last_lane;

endmodule
`default_nettype wire

// File: rtl/output_drain_controller.sv
`default_nettype none
// ============================================================================
//  output_drain_controller
//  Walks the output BRAM rows in external-read mode and streams them out.
//  Revision: 1.0
// ============================================================================
module output_drain_controller
  import output_drain_controller_pkg::*;
#(
  parameter int DW         = 16,
  parameter int NUM_BRAMS  = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            conv_mode,
  input  logic [ADDR_WIDTH-1:0]           base_addr,
  input  logic [ADDR_WIDTH:0]             num_rows,
  output logic                            ext_read_mode,
  output logic [NUM_BRAMS*ADDR_WIDTH-1:0] ext_read_addr_flat,
  output logic                            conv_output_bram_dest,
  input  logic [NUM_BRAMS*DW-1:0]         bram_read_data_flat,
  output logic [DW-1:0]                   m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic                            busy,
  output logic                            done
);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_num_rows;
  logic [ADDR_WIDTH:0]   r_row;
  logic [WAIT_W-1:0]     r_wait;

  logic                  w_active;
  logic                  w_done;
  logic                  w_load;
  logic                  w_row_done;
  logic                  w_last_row;
  logic [WAIT_W-1:0]     w_latency;
  logic [ADDR_WIDTH-1:0] w_addr;

  assign w_last_row = (r_row == r_num_rows - (ADDR_WIDTH+1)'(1));
  assign w_latency  = r_mode ? WAIT_W'(LAT_TRANSCONV) : WAIT_W'(LAT_1DCONV);

  always_comb begin
    w_state_next = r_state;
    w_active     = 1'b0;
    w_done       = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = (num_rows != '0) ? ST_ISSUE : ST_DONE;
      end
      ST_ISSUE: begin
        w_active     = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        w_active = 1'b1;
        // Row buffer loads on the edge L+1 cycles after the address appeared
        if (r_wait == WAIT_W'(1)) begin
          w_load       = 1'b1;
          w_state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_active     = 1'b1;
        w_state_next = ST_STREAM;
      end
      ST_STREAM: begin
        w_active = 1'b1;
        if (w_row_done) w_state_next = w_last_row ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_mode     <= 1'b0;
      r_base     <= '0;
      r_num_rows <= '0;
      r_row      <= '0;
      r_wait     <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && start) begin
        r_mode     <= conv_mode;
        r_base     <= base_addr;
        r_num_rows <= num_rows;
        r_row      <= '0;
      end
      if (r_state == ST_ISSUE) begin
        r_wait <= w_latency;
      end else if (r_state == ST_WAIT && r_wait != WAIT_W'(1)) begin
        r_wait <= r_wait - WAIT_W'(1);
      end
      if (r_state == ST_STREAM && w_row_done) r_row <= r_row + (ADDR_WIDTH+1)'(1);
    end
  end

  // Address wraps naturally at the top of the BRAM
  assign w_addr = w_active ? (r_base + r_row[ADDR_WIDTH-1:0]) : '0;

  for (genvar g = 0; g < NUM_BRAMS; g++) begin : g_lane_addr
    assign ext_read_addr_flat[g*ADDR_WIDTH +: ADDR_WIDTH] = w_addr;
  end

  assign ext_read_mode         = w_active;
  assign conv_output_bram_dest = w_active;
  assign busy                  = w_active;
  assign done                  = w_done;

  output_drain_controller_row_serializer #(
    .DW        (DW),
    .NUM_BRAMS (NUM_BRAMS)
  ) u_row_serializer (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_load          (w_load),
    .i_last_row      (w_last_row),
    .i_enable        (r_state == ST_STREAM),
    .i_row_data_flat (bram_read_data_flat),
    .i_tready        (m_tready),
    .o_tdata         (m_tdata),
    .o_tvalid        (m_tvalid),
    .o_tlast         (m_tlast),
    .o_row_done      (w_row_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_output_drain_controller.sv
`default_nettype none
// ============================================================================
//  tb_output_drain_controller
//  Directed drains against a latency-accurate BRAM wrapper model.
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_output_drain_controller;

  localparam int DW = 16;
  localparam int NB = 16;
  localparam int AW = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              conv_mode;
  logic [AW-1:0]     base_addr;
  logic [AW:0]       num_rows;
  logic              ext_read_mode;
  logic [NB*AW-1:0]  ext_read_addr_flat;
  logic              conv_output_bram_dest;
  logic [NB*DW-1:0]  bram_read_data_flat;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic              busy;
  logic              done;

  output_drain_controller dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start                 (start),
    .conv_mode             (conv_mode),
    .base_addr             (base_addr),
    .num_rows              (num_rows),
    .ext_read_mode         (ext_read_mode),
    .ext_read_addr_flat    (ext_read_addr_flat),
    .conv_output_bram_dest (conv_output_bram_dest),
    .bram_read_data_flat   (bram_read_data_flat),
    .m_tdata               (m_tdata),
    .m_tvalid              (m_tvalid),
    .m_tready              (m_tready),
    .m_tlast               (m_tlast),
    .busy                  (busy),
    .done                  (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // BRAM wrapper model: lane word = addr*16+lane, 1 or 2 register stages
  function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a, input int lane);
    return DW'(int'(a) * NB + lane);
  endfunction

  int               tb_lat = 2;
  logic [NB*AW-1:0] a1 = '0, a2 = '0;
  logic             m1 = 1'b0, m2 = 1'b0;
  always @(posedge clk) begin
    a1 <= ext_read_addr_flat;
    m1 <= ext_read_mode;
    a2 <= a1;
    m2 <= m1;
  end
  always_comb begin
    bram_read_data_flat = '0;
    for (int i = 0; i < NB; i++) begin
      if (tb_lat == 1)
        bram_read_data_flat[i*DW +: DW] = m1 ? bram_word(a1[i*AW +: AW], i) : 16'hDEAD;
      else
        bram_read_data_flat[i*DW +: DW] = m2 ? bram_word(a2[i*AW +: AW], i) : 16'hDEAD;
    end
  end

  // Scoreboard queues and monitor state
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            acc_cnt = 0;
  int            acc_cyc = 0;
  int            exp_lead = 4;
  int            lead = 0;
  bit            seen_mode = 0, seen_valid = 0;
  bit            prev_stall = 0, prev_mode = 0, awaiting = 0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
      prev_mode  = 0;
      awaiting   = 0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_tvalid, 1'b1);
        check("hold_data", m_tdata, prev_data);
        check("hold_last", m_tlast, prev_last);
      end
      if (ext_read_mode) seen_mode = 1;
      if (m_tvalid) seen_valid = 1;
      if (ext_read_mode && (!prev_mode || ext_read_addr_flat[AW-1:0] != prev_addr)) begin
        bit bc_ok;
        bc_ok = 1;
        for (int i = 1; i < NB; i++)
          if (ext_read_addr_flat[i*AW +: AW] !== ext_read_addr_flat[AW-1:0]) bc_ok = 0;
        check("addr_bcast", bc_ok, 1'b1);
        check("addr_expected", addr_q.size() != 0, 1'b1);
        if (addr_q.size() != 0) check("row_addr", ext_read_addr_flat[AW-1:0], addr_q.pop_front());
        lead     = 1;
        awaiting = 1;
      end else if (ext_read_mode && awaiting && !m_tvalid) begin
        lead++;
      end
      if (m_tvalid && awaiting) begin
        check("read_lead", lead, exp_lead);
        awaiting = 0;
      end
      if (m_tvalid && m_tready) begin
        check("word_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("word", {m_tlast, m_tdata}, exp_q.pop_front());
        acc_cnt++;
        if (m_tlast) acc_cyc = cyc;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      prev_mode  = ext_read_mode;
      prev_addr  = ext_read_addr_flat[AW-1:0];
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mode"}, ext_read_mode, 1'b0);
    check({tag, "_dest"}, conv_output_bram_dest, 1'b0);
    check({tag, "_addr"}, |ext_read_addr_flat, 1'b0);
    check({tag, "_tvalid"}, m_tvalid, 1'b0);
    check({tag, "_tdata"}, m_tdata, '0);
    check({tag, "_tlast"}, m_tlast, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  task automatic push_expect(input logic mode, input int base, input int rows);
    tb_lat   = mode ? 1 : 2;
    exp_lead = tb_lat + 2;
    for (int r = 0; r < rows; r++) begin
      addr_q.push_back(AW'(base + r));
      for (int i = 0; i < NB; i++)
        exp_q.push_back({(r == rows - 1 && i == NB - 1), bram_word(AW'(base + r), i)});
    end
  endtask

  bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic do_drain(input logic mode, input int base, input int rows,
                          input bit bp, input int poke_at);
    int it, busy_low, k, done_cyc;
    bit got;
    push_expect(mode, base, rows);
    seen_mode  = 0;
    seen_valid = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    conv_mode = mode;
    base_addr = AW'(base);
    num_rows  = (AW+1)'(rows);
    @(posedge clk); #1;
    start    = 1'b0;
    m_tready = 1'b1;
    it = 0; got = 0; busy_low = 0; k = 0; done_cyc = 0;
    while (!got && it < 25000) begin
      @(negedge clk);
      it++;
      if (done) begin
        got      = 1;
        done_cyc = cyc;
      end else if (rows > 0 && !busy) begin
        busy_low++;
      end
      if (!got) begin
        @(posedge clk); #1;
        m_tready = bp ? pat[k % 4] : 1'b1;
        k++;
        if (it == poke_at) begin
          start     = 1'b1;
          conv_mode = ~mode;
          base_addr = AW'(base + 300);
          num_rows  = (AW+1)'(5);
        end else begin
          start = 1'b0;
        end
      end
    end
    check("done_seen", got, 1'b1);
    check("busy_at_done", busy, 1'b0);
    check("mode_at_done", ext_read_mode, 1'b0);
    check("valid_at_done", m_tvalid, 1'b0);
    if (rows == 0) begin
      check("done_latency", it, 1);
      check("mode_never", seen_mode, 1'b0);
      check("valid_never", seen_valid, 1'b0);
    end else begin
      check("busy_span", busy_low, 0);
      check("done_after_last", done_cyc - acc_cyc, 1);
    end
    check("words_left", exp_q.size(), 0);
    check("addrs_left", addr_q.size(), 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      start    = 1'b0;
      m_tready = 1'b1;
      @(negedge clk);
      check("post_done", done, 1'b0);
      check("post_mode", ext_read_mode, 1'b0);
      check("post_valid", m_tvalid, 1'b0);
    end
  endtask

  initial begin
    int it, acc0;
    rst_n     = 1'b0;
    start     = 1'b0;
    conv_mode = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    m_tready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_drain(1'b0, 0, 2, 1'b0, -1);      // 1DCONV, two rows, full ready
    do_drain(1'b1, 5, 1, 1'b0, -1);      // TRANSCONV single row
    do_drain(1'b0, 20, 3, 1'b1, -1);     // backpressure, 1DCONV
    do_drain(1'b1, 900, 2, 1'b1, -1);    // backpressure, TRANSCONV
    do_drain(1'b1, 1023, 3, 1'b0, -1);   // address wrap
    do_drain(1'b0, 7, 0, 1'b0, -1);      // zero rows
    do_drain(1'b1, 100, 1, 1'b0, 5);     // start and parameter changes while busy

    // Reset in the middle of streaming lane 7
    push_expect(1'b0, 40, 2);
    acc0 = acc_cnt;
    @(posedge clk); #1;
    start     = 1'b1;
    conv_mode = 1'b0;
    base_addr = AW'(40);
    num_rows  = (AW+1)'(2);
    @(posedge clk); #1;
    start    = 1'b0;
    m_tready = 1'b1;
    it = 0;
    while (acc_cnt - acc0 < 7 && it < 200) begin
      @(posedge clk); #1;
      it++;
    end
    check("reach_lane7", acc_cnt - acc0, 7);
    check("valid_at_lane7", m_tvalid, 1'b1);
    rst_n    = 1'b0;
    m_tready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("midrst");
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    rst_n    = 1'b1;
    m_tready = 1'b1;
    do_drain(1'b0, 40, 2, 1'b0, -1);     // clean drain after reset

    do_drain(1'b1, 512, 1024, 1'b0, -1); // whole BRAM

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
